// File: rtl/pdu_dma_reader_if.sv
// Request, buffer read-port and egress stream signals of the PDU DMA reader.
// The master modport is the reader; the slave modport is its environment.
interface pdu_dma_reader_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 512
);
    logic          dma_start;
    logic [AW-1:0] dma_size;
    logic [AW-1:0] dma_base_addr;
    logic          dma_done;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;

    modport master (
        input  dma_start, dma_size, dma_base_addr, rd_valid, rd_data, out_ready,
        output dma_done, busy, rd_en, rd_addr, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        output dma_start, dma_size, dma_base_addr, rd_valid, rd_data, out_ready,
        input  dma_done, busy, rd_en, rd_addr, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/pdu_dma_reader.sv
// Reads one {base, size} request of flits from the ring buffer's BRAM port and
// streams them out through a skid FIFO with sop/eop framing and a done pulse.
module pdu_dma_reader #(
    parameter int unsigned PDU_DEPTH  = 512,
    parameter int unsigned PDU_AWIDTH = $clog2(PDU_DEPTH),
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    pdu_dma_reader_if.master   bus
);
    localparam int unsigned AW    = PDU_AWIDTH;
    localparam int unsigned CW    = PDU_AWIDTH + 1;
    localparam int unsigned DW    = 512;
    localparam int unsigned FW    = $clog2(FIFO_DEPTH);
    localparam int unsigned OW    = FW + 2;
    localparam int unsigned DROPW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   base;
    logic [CW-1:0]   size;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   sent;
    logic [FW:0]     inflight;
    logic [FW:0]     count;
    logic [FW-1:0]   wr_ptr;
    logic [FW-1:0]   rd_ptr;
    logic [DROPW-1:0] drop_cnt;
    logic [DW-1:0]   mem [FIFO_DEPTH];

    logic            push;
    logic            pop;
    logic            can_issue;
    logic [OW-1:0]   occupancy;

    // Beats still in the BRAM pipe when reset released belong to the old request.
    assign push = bus.rd_valid && (drop_cnt == DROPW'(RD_LATENCY));
    assign pop  = bus.out_valid && bus.out_ready;

    // A read registered this cycle is not yet in inflight, so count it too.
    assign occupancy = OW'(count) + OW'(inflight) + OW'(bus.rd_en);
    assign can_issue = (issued < size) && (occupancy < OW'(FIFO_DEPTH));

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_sop   = bus.out_valid && (sent == '0);
    assign bus.out_eop   = bus.out_valid && (sent == size - CW'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base         <= '0;
            size         <= '0;
            issued       <= '0;
            sent         <= '0;
            inflight     <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            drop_cnt     <= '0;
            bus.dma_done <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rd_en    <= 1'b0;
            bus.rd_addr  <= '0;
        end else begin
            bus.dma_done <= 1'b0;
            bus.rd_en    <= 1'b0;

            if (drop_cnt != DROPW'(RD_LATENCY)) begin
                drop_cnt <= drop_cnt + DROPW'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + FW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FW'(1);
                sent   <= sent + CW'(1);
            end
            count    <= count + (FW + 1)'(push) - (FW + 1)'(pop);
            inflight <= inflight + (FW + 1)'(bus.rd_en) - (FW + 1)'(push);

            case (state)
                IDLE: begin
                    if (bus.dma_start) begin
                        base     <= bus.dma_base_addr;
                        size     <= CW'(bus.dma_size);
                        sent     <= '0;
                        bus.busy <= 1'b1;
                        if (bus.dma_size == '0) begin
                            issued       <= '0;
                            state        <= DONE;
                            bus.dma_done <= 1'b1;
                        end else begin
                            // First read leaves together with the state change.
                            issued      <= CW'(1);
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= bus.dma_base_addr;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    if (issued >= size) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= base + issued[AW-1:0];
                        issued      <= issued + CW'(1);
                        if (issued + CW'(1) == size) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && bus.out_eop) begin
                        state        <= DONE;
                        bus.dma_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdu_dma_reader.sv
// Scoreboard bench for pdu_dma_reader: a BRAM model feeds random flit data and
// a monitor compares read addresses and egress flits against expected queues.
module tb_pdu_dma_reader;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned FD    = 8;
    localparam int unsigned RL    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pdu_dma_reader_if #(.AW(AW), .DW(512)) bus ();

    pdu_dma_reader #(
        .PDU_DEPTH(DEPTH), .PDU_AWIDTH(AW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [511:0] mem [DEPTH];
    logic          v_pipe = 1'b0;
    logic [AW-1:0] a_pipe = '0;

    // Two-cycle BRAM read port; keeps answering across reset like the real one.
    always @(posedge clk) begin
        v_pipe       <= bus.rd_en;
        a_pipe       <= bus.rd_addr;
        bus.rd_valid <= v_pipe;
        bus.rd_data  <= mem[a_pipe];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int rd_cnt, hs_cnt, done_cnt = 0, done_base;
    int start_cyc, first_rd_cyc, last_rd_cyc, last_hs_cyc, done_cyc;
    int addr_q[$];
    logic [513:0] flit_q[$];
    logic [513:0] held, cur;
    bit held_v = 0;

    task automatic chk(input string name, input logic [513:0] act, input logic [513:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [513:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Cycle counter and egress ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: read addresses, egress flits, stall stability, done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 0;
                continue;
            end
            if (bus.rd_en) begin
                rd_cnt++;
                if (rd_cnt == 1) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                if (addr_q.size() == 0) fail("rd_unexpected", 514'(bus.rd_addr));
                else chk("rd_addr", 514'(bus.rd_addr), 514'(addr_q.pop_front()));
            end
            if (bus.out_valid) begin
                cur = {bus.out_sop, bus.out_eop, bus.out_data};
                if (held_v) chk("stall_stable", cur, held);
                if (bus.out_ready) begin
                    held_v = 0;
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    if (flit_q.size() == 0) fail("flit_unexpected", cur);
                    else chk("flit", cur, flit_q.pop_front());
                end else begin
                    held_v = 1;
                    held = cur;
                end
            end else if (held_v) begin
                fail("valid_dropped_while_stalled", 514'(0));
                held_v = 0;
            end
            if (bus.dma_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all_flits", 514'(flit_q.size()), 514'(0));
            end
        end
    end

    task automatic start_req(input int base, input int size);
        int a;
        @(posedge clk);
        #1;
        for (int i = 0; i < size; i++) begin
            a = (base + i) % DEPTH;
            addr_q.push_back(a);
            flit_q.push_back({(i == 0), (i == size - 1), mem[a]});
        end
        rd_cnt = 0;
        hs_cnt = 0;
        done_base = done_cnt;
        start_cyc = cyc;
        bus.dma_start = 1'b1;
        bus.dma_size = AW'(size);
        bus.dma_base_addr = AW'(base);
        @(posedge clk);
        #1;
        bus.dma_start = 1'b0;
        bus.dma_size = AW'($urandom);
        bus.dma_base_addr = AW'($urandom);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && done_cnt == done_base; i++) @(posedge clk);
        if (done_cnt == done_base) fail("done_timeout", 514'(cyc));
        @(negedge clk);
        chk("busy_after_done", 514'(bus.busy), 514'(0));
        repeat (3) @(posedge clk);
        chk("done_pulse_count", 514'(done_cnt - done_base), 514'(1));
        chk("addr_q_drained", 514'(addr_q.size()), 514'(0));
        chk("flit_q_drained", 514'(flit_q.size()), 514'(0));
    endtask

    task automatic check_idle_outputs(input string name);
        chk(name, {bus.dma_done, bus.busy, bus.rd_en, bus.out_valid, bus.out_sop,
                   bus.out_eop, 514'(bus.rd_addr)} , 520'(0));
    endtask

    initial begin
        int b, s;
        for (int i = 0; i < int'(DEPTH); i++)
            for (int j = 0; j < 16; j++) mem[i][j*32 +: 32] = $urandom;
        bus.dma_start = 1'b0;
        bus.dma_size = '0;
        bus.dma_base_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back reads, framing and timing with ready held high.
        ready_mode = 0;
        start_req(10, 4);
        wait_done(200);
        chk("first_rd_latency", 514'(first_rd_cyc - start_cyc), 514'(1));
        chk("reads_back_to_back", 514'(last_rd_cyc - first_rd_cyc), 514'(3));
        chk("flit_count_4", 514'(hs_cnt), 514'(4));
        chk("done_after_eop", 514'(done_cyc - last_hs_cyc), 514'(1));

        // Address wrap at the top of the ring.
        start_req(DEPTH - 2, 4);
        wait_done(200);
        chk("wrap_flit_count", 514'(hs_cnt), 514'(4));

        // Long stall: reads must stop at the FIFO capacity.
        ready_mode = 2;
        start_req($urandom_range(0, DEPTH - 1), 32);
        repeat (20) @(posedge clk);
        chk("stall_reads_bounded", 514'(rd_cnt <= int'(FD)), 514'(1));
        chk("stall_reads_fill", 514'(rd_cnt), 514'(FD));
        chk("stall_no_handshake", 514'(hs_cnt), 514'(0));
        ready_mode = 0;
        wait_done(500);
        chk("stall_flit_count", 514'(hs_cnt), 514'(32));

        // Zero-length request.
        start_req(77, 0);
        wait_done(20);
        chk("zero_done_latency", 514'((done_cyc - start_cyc) inside {[1:2]}), 514'(1));
        chk("zero_no_reads", 514'(rd_cnt), 514'(0));
        chk("zero_no_flits", 514'(hs_cnt), 514'(0));

        // Single flit; a second start while busy must be ignored.
        start_req(300, 1);
        bus.dma_start = 1'b1;
        bus.dma_size = AW'(5);
        bus.dma_base_addr = AW'(100);
        @(posedge clk);
        #1 bus.dma_start = 1'b0;
        wait_done(50);
        repeat (10) @(posedge clk);
        chk("single_reads", 514'(rd_cnt), 514'(1));
        chk("single_flits", 514'(hs_cnt), 514'(1));
        chk("ignored_start_no_done", 514'(done_cnt - done_base), 514'(1));

        // Reset in the middle of a transfer.
        start_req($urandom_range(0, DEPTH - 1), 16);
        for (int i = 0; i < 200 && hs_cnt < 5; i++) @(posedge clk);
        chk("reset_test_reached_5", 514'(hs_cnt >= 5), 514'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        addr_q.delete();
        flit_q.delete();
        done_base = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset_outputs");
        for (int i = 0; i < int'(RL) + 3; i++) begin
            @(negedge clk);
            chk("stale_beats_dropped", 514'(bus.out_valid), 514'(0));
        end
        chk("mid_reset_no_done", 514'(done_cnt - done_base), 514'(0));
        start_req(0, 2);
        wait_done(100);
        chk("post_reset_flits", 514'(hs_cnt), 514'(2));

        // Randomised requests with random backpressure.
        ready_mode = 1;
        for (int n = 0; n < 12; n++) begin
            b = $urandom_range(0, DEPTH - 1);
            s = $urandom_range(1, 40);
            start_req(b, s);
            wait_done(1000);
            chk("rand_flit_count", 514'(hs_cnt), 514'(s));
        end

        // Largest request the size field can express.
        start_req($urandom_range(0, DEPTH - 1), DEPTH - 1);
        wait_done(5000);
        chk("max_size_flits", 514'(hs_cnt), 514'(DEPTH - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
